// File: rtl/cdc_pkg.sv
// Shared types for the toggle req/ack clock-domain-crossing pair.
// The destination-end block will reuse the state encoding.
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_tx_state_t;

endpackage

// File: rtl/synchronizer_ff.sv
// Multi-stage flop chain that resynchronizes an asynchronous signal onto clk.
// Every stage resets to 0 so both protocol toggles start aligned.
module synchronizer_ff #(
  parameter int DATA_WIDTH = 1,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_stage [SYNC_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_stage[gi] <= '0;
        end else if (gi == 0) begin
          r_stage[gi] <= i_d;
        end else begin
          r_stage[gi] <= r_stage[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign o_q = r_stage[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a two-phase req/ack CDC link: holds one word stable while its
// request toggle is outstanding, with an optional sticky ack watchdog.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  cdc_tx_state_t         r_state;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_ack_sync;
  logic                  w_accept;

  synchronizer_ff #(
    .DATA_WIDTH(1),
    .SYNC_DEPTH(SYNC_DEPTH)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack_in),
    .o_q (w_ack_sync)
  );

  assign w_accept = (r_state == IDLE) && in_valid;

  // A stray ack toggle seen in IDLE is never examined here; it only matters
  // once the next request is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_req   <= ~r_req;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_ack_sync == r_req) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE);
  assign busy     = ~in_ready;
  assign data_out = r_data;
  assign req_out  = r_req;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
      localparam logic [TW-1:0] THIT = TW'(TIMEOUT_CYCLES - 1);

      logic [TW-1:0] r_timer;
      logic          r_err;
      logic          w_hit;

      // Set fires on the edge where the timer steps onto TMAX.
      assign w_hit = (r_state == WAIT_ACK) && (r_timer == THIT);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_timer <= '0;
          r_err   <= 1'b0;
        end else begin
          if (w_accept) begin
            r_timer <= '0;
          end else if ((r_state == WAIT_ACK) && (r_timer != TMAX)) begin
            r_timer <= r_timer + 1'b1;
          end
          if (w_hit) begin
            r_err <= 1'b1;
          end else if (err_clr) begin
            r_err <= 1'b0;
          end
        end
      end

      assign err = r_err;
    end else begin : g_no_wdog
      assign err = 1'b0;
    end
  endgenerate

endmodule
